// File: rtl/result_uart_tx_pkg.sv
// Shared types and constants for the result UART transmitter.
// The PARITY state is only entered when RESULT_UART_TX_PARITY_EN is defined.
package result_uart_tx_pkg;

    localparam int unsigned STAT_STROBE = 0;
    localparam int unsigned STAT_HALT   = 1;
    localparam int unsigned STAT_CNT_LO = 2;
    localparam int unsigned STAT_CNT_HI = 3;

    localparam logic UART_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Byte serializer: start, 8 data bits LSB first, optional even parity
// (RESULT_UART_TX_PARITY_EN), stop. Accepts a byte on valid_i && ready_c_o.
module uart_tx_core
    import result_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_c_o,
    output logic       txd_o,
    output logic       active_o
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          txd_q, txd_d;
    logic          active_q, active_d;
    logic          bit_end;

    assign bit_end   = (timer_q == BIT_LAST);
    assign txd_o     = txd_q;
    assign active_o  = active_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            txd_q    <= UART_IDLE;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            txd_q    <= txd_d;
            active_q <= active_d;
        end
    end

    // Next state; the bit-timer restarts from zero on every state change.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        idx_d     = idx_q;
        data_d    = data_q;
        ready_c_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (valid_i) begin
                    ready_c_o = 1'b1;
                    data_d    = data_i;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef RESULT_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef RESULT_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    // Back-to-back frames: pop the next byte straight from STOP.
                    if (valid_i) begin
                        ready_c_o = 1'b1;
                        data_d    = data_i;
                        state_d   = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                timer_d = '0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        active_d = (state_d != ST_IDLE);

        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = data_d[idx_d];
`ifdef RESULT_UART_TX_PARITY_EN
            ST_PARITY: txd_d = even_parity(data_d);
`endif
            default:   txd_d = UART_IDLE;
        endcase
    end

endmodule

// File: rtl/result_uart_tx.sv
// Stages core results, queues their bytes in a FIFO and sends them over UART.
// Even parity framing is enabled by defining RESULT_UART_TX_PARITY_EN.
module result_uart_tx
    import result_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] status,
    input  logic [31:0] result_bytes,
    output logic        txd,
    output logic        busy,
    output logic        overflow,
    output logic        done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    logic [31:0]   stg_data_q, stg_data_d;
    logic [2:0]    stg_cnt_q, stg_cnt_d;
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic          ovf_q, ovf_d;

    logic strobe, capture, push, pop;
    logic stg_valid, fifo_valid, fifo_full, core_active;
    logic unused_status;

    assign unused_status = ^status[31:4];

    assign strobe     = status[STAT_STROBE];
    assign stg_valid  = (stg_cnt_q != 3'd0);
    assign fifo_valid = (fifo_cnt_q != '0);
    assign fifo_full  = (fifo_cnt_q == FIFO_FULL);
    assign capture    = strobe && !stg_valid;
    // A full FIFO still takes a byte when the transmitter pops in the same cycle.
    assign push       = stg_valid && (!fifo_full || pop);

    always_comb begin
        stg_data_d = stg_data_q;
        stg_cnt_d  = stg_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        ovf_d      = ovf_q | (strobe & stg_valid);

        if (capture) begin
            stg_data_d = result_bytes;
            stg_cnt_d  = 3'(status[STAT_CNT_HI:STAT_CNT_LO]) + 3'd1;
        end else if (push) begin
            stg_data_d = {8'h00, stg_data_q[31:8]};
            stg_cnt_d  = stg_cnt_q - 3'd1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CW'(1);
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_data_q <= '0;
            stg_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            stg_data_q <= stg_data_d;
            stg_cnt_q  <= stg_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage array needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= stg_data_q[7:0];
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .data_i   (fifo_mem_q[rd_ptr_q]),
        .valid_i  (fifo_valid),
        .ready_c_o(pop),
        .txd_o    (txd),
        .active_o (core_active)
    );

    assign overflow = ovf_q;
    assign busy     = stg_valid | fifo_valid | core_active;
    assign done     = status[STAT_HALT] & ~busy;

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Parameter FIFO_DEPTH, default 16, byte FIFO entries; power of two, minimum 4.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 status  input  32  core status: [0] result strobe (one-cycle pulse); [1] core halted (level); [3:2] byte count minus one; [31:4] ignored.
REQ-006 result_bytes  input  32  result payload from core, valid in the strobe cycle; byte 0 = [7:0].
REQ-007 txd  output  1  UART serial line; idle high.
REQ-008 busy  output  1  high while the staging register, FIFO or transmitter holds data.
REQ-009 overflow  output  1  sticky; set when any result byte is dropped.
REQ-010 done  output  1  high when status[1]=1 and busy=0.

Function
REQ-011 On status[0]=1 with the staging register empty, capture result_bytes and count N=status[3:2]+1 into the staging register; the capture cycle is the strobe cycle.
REQ-012 On status[0]=1 with the staging register non-empty, drop the whole new result and set overflow; staged contents are unaffected.
REQ-013 The staging register pushes one byte per cycle into the FIFO, lowest byte first, starting the cycle after capture, stalling while the FIFO is full.
REQ-014 The staging register becomes empty in the cycle its last byte is pushed; a strobe in that same cycle is dropped (REQ-012).
REQ-015 FIFO full = FIFO_DEPTH entries; push and pop in the same cycle when full or empty are both legal and leave the count unchanged (the empty-FIFO case is a bypass of at most one cycle, no data lost).
REQ-016 FIFO pointers wrap modulo FIFO_DEPTH.
REQ-017 Transmitter FSM states: IDLE, START, DATA, STOP (PARITY added per REQ-026).
REQ-018 IDLE -> START when the FIFO is non-empty; the byte is popped in that transition cycle; txd=0 from the next cycle.
REQ-019 Each bit state lasts exactly CLKS_PER_BIT cycles, counted by a bit-timer reloaded on every state change.
REQ-020 DATA sends 8 bits LSB first, driven by a 3-bit index that wraps 7 -> 0 on exit to STOP.
REQ-021 STOP drives txd=1 for one bit time, then enters START if the FIFO is non-empty (back-to-back, no idle gap), otherwise IDLE.
REQ-022 busy = staging non-empty OR FIFO non-empty OR FSM not in IDLE; done is combinational from status[1] and busy.
REQ-023 overflow clears only on rst.

Reset
REQ-024 When rst=1 at a clock edge: FSM=IDLE, txd=1, staging empty, FIFO pointers and count zero, bit-timer and index zero, overflow=0; busy=0 from the next cycle.
REQ-025 Reset asserted mid-frame aborts the frame immediately; txd returns high in the cycle after the reset edge; no partial byte is resumed.

Configuration
REQ-026 Macro RESULT_UART_TX_PARITY_EN defined: a PARITY state between DATA and STOP sends the even-parity bit (XOR of the 8 data bits) for one bit time, making 11 bit times per frame; undefined: no PARITY state, 8N1, 10 bit times per frame.

Structure
REQ-027 Package result_uart_tx_pkg holds the FSM state enumeration, the status bit-position constants (strobe=0, halt=1, count=3:2) and the UART idle-level constant.
REQ-028 The serializer (FSM, bit-timer, index) is a sub-module uart_tx_core with a valid/ready byte input; the staging register and FIFO stay in result_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Single byte: strobe, result_bytes=0x000000A5, count field 0 -> txd low 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles; busy falls after stop.
REQ-030 Four bytes: result_bytes=0x44332211, count field 3 -> frames 0x11, 0x22, 0x33, 0x44 in order with no idle gap between stop and next start.
REQ-031 Overflow: two 4-byte strobes one cycle apart -> second dropped, overflow=1 and held; only 4 frames sent.
REQ-032 FIFO full: three back-to-back 4-byte strobes, each after staging empties -> staging stalls while FIFO full, no byte lost, 12 frames in order, overflow=0.
REQ-033 Reset mid-frame: rst pulsed during DATA bit 3 -> txd=1 next cycle, busy=0, FIFO empty, no further frames.
REQ-034 Done/parity: status[1]=1 while a frame is in flight -> done=0 until stop ends, then 1; with RESULT_UART_TX_PARITY_EN, byte 0x07 sends parity bit 1 before stop.
